// File: rtl/rr_grant_sched16.sv
// Round-robin scheduler sharing one 16-way decoded resource.
// Holds a registered grant until done, request drop or hold timeout.
module rr_grant_sched16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        done,
  output logic        gnt_valid,
  output logic [3:0]  gnt_idx,
  output logic [15:0] gnt
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam bit       TMO_EN = (MAX_HOLD != 0);
  localparam logic [7:0] LAST = 8'(MAX_HOLD - 1);

  state_t      state, state_nx;
  logic [3:0]  ptr, ptr_nx;
  logic [7:0]  hold_cnt, hold_nx;
  logic        valid_nx;
  logic [3:0]  idx_nx;
  logic [15:0] gnt_nx;
  logic [3:0]  win;
  logic [3:0]  scan;
  logic        rel;

  // Downward scan so the last hit is the nearest one at or after ptr.
  always_comb begin
    win  = ptr;
    scan = '0;
    for (int k = 15; k >= 0; k--) begin
      scan = ptr + 4'(k);
      if (req[scan]) win = scan;
    end
  end

  assign rel = done | ~req[gnt_idx] |
               (TMO_EN && hold_cnt == LAST);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    valid_nx = gnt_valid;
    idx_nx   = gnt_idx;
    unique case (state)
      IDLE: begin
        if (en && |req) begin
          state_nx = GRANT;
          valid_nx = 1'b1;
          idx_nx   = win;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_nx = IDLE;
          valid_nx = 1'b0;
          ptr_nx   = gnt_idx + 4'd1;
        end else if (hold_cnt != 8'hFF) begin
          hold_nx = hold_cnt + 8'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    gnt_nx = valid_nx ? (16'h0001 << idx_nx) : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      gnt       <= '0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      gnt_valid <= valid_nx;
      gnt_idx   <= idx_nx;
      gnt       <= gnt_nx;
    end
  end

endmodule

// File: tb/tb_rr_grant_sched16.sv
// Bench for rr_grant_sched16: vector table, corner sequences,
// and random traffic against a queue-free scan model.
module tb_rr_grant_sched16;

  localparam int MH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        done = 1'b0;
  logic [15:0] req = '0;
  logic        gnt_valid;
  logic [3:0]  gnt_idx;
  logic [15:0] gnt;

  int n_tests = 0;
  int n_fail = 0;

  bit m_valid = 0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_held = 0;

  typedef struct {
    bit          en;
    logic [15:0] req;
    bit          done;
    bit          ev;
    int          ei;
  } vec_t;

  vec_t vecs[11];

  rr_grant_sched16 #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .done     (done),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx),
    .gnt      (gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, bit ev, int ei);
    logic [15:0] eg;
    eg = ev ? 16'(1 << ei) : 16'h0000;
    n_tests++;
    if (gnt_valid !== ev || gnt_idx !== 4'(ei) || gnt !== eg) begin
      n_fail++;
      $display("FAIL %s: got valid=%0b idx=%0d gnt=%h, want valid=%0b idx=%0d gnt=%h",
               name, gnt_valid, gnt_idx, gnt, ev, ei, eg);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_idx = 0;
    m_ptr = 0;
    m_held = 0;
  endtask

  // Grant goes to the first requester found walking up from the pointer.
  task automatic model_step();
    bit found;
    int j;
    found = 0;
    if (!m_valid) begin
      if (en && req != 0) begin
        for (int k = 0; k < 16; k++) begin
          j = (m_ptr + k) % 16;
          if (!found && req[j]) begin
            found = 1;
            m_valid = 1;
            m_idx = j;
            m_held = 1;
          end
        end
      end
    end else if (done || !req[m_idx] || (MH != 0 && m_held == MH)) begin
      m_valid = 0;
      m_ptr = (m_idx + 1) % 16;
    end else begin
      m_held++;
    end
  endtask

  task automatic cyc(bit e, logic [15:0] r, bit d);
    en = e;
    req = r;
    done = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [15:0] r;
    bit e;
    bit d;

    vecs[0]  = '{1, 16'h0020, 0, 1, 5};
    vecs[1]  = '{1, 16'h0020, 1, 0, 5};
    vecs[2]  = '{0, 16'h0020, 0, 0, 5};
    vecs[3]  = '{1, 16'h8008, 0, 1, 15};
    vecs[4]  = '{1, 16'h8008, 1, 0, 15};
    vecs[5]  = '{1, 16'h8008, 0, 1, 3};
    vecs[6]  = '{1, 16'h8008, 0, 1, 3};
    vecs[7]  = '{1, 16'h8000, 0, 0, 3};
    vecs[8]  = '{1, 16'h0000, 0, 0, 3};
    vecs[9]  = '{1, 16'h0001, 0, 1, 0};
    vecs[10] = '{1, 16'h0001, 1, 0, 0};

    #1;
    rst = 1'b1;
    #1;
    chk("reset_async", 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (5) begin
      cyc(1, 16'h0000, 0);
      chk("idle_req0", 0, 0);
    end

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].req, vecs[i].done);
      chk($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei);
    end

    do_reset();
    for (int k = 0; k <= 16; k++) begin
      cyc(1, 16'hFFFF, 0);
      chk($sformatf("rr_grant%0d", k), 1, k % 16);
      cyc(1, 16'hFFFF, 1);
      chk($sformatf("rr_gap%0d", k), 0, k % 16);
    end

    do_reset();
    cyc(1, 16'h4000, 0);
    chk("wrap_g14", 1, 14);
    cyc(1, 16'h4000, 1);
    chk("wrap_r14", 0, 14);
    cyc(1, 16'h8008, 0);
    chk("wrap_g15", 1, 15);
    cyc(1, 16'h8008, 1);
    chk("wrap_r15", 0, 15);
    cyc(1, 16'h8008, 0);
    chk("wrap_g3", 1, 3);
    cyc(1, 16'h8008, 1);
    chk("wrap_r3", 0, 3);

    do_reset();
    cyc(1, 16'h0004, 0);
    chk("tmo_start", 1, 2);
    repeat (7) begin
      cyc(1, 16'h0004, 0);
      chk("tmo_hold", 1, 2);
    end
    cyc(1, 16'h0004, 0);
    chk("tmo_release", 0, 2);
    cyc(1, 16'h0004, 0);
    chk("tmo_regrant_sole", 1, 2);
    repeat (7) begin
      cyc(1, 16'h0004, 0);
      chk("tmo_hold2", 1, 2);
    end
    cyc(1, 16'h0004, 0);
    chk("tmo_release2", 0, 2);
    cyc(1, 16'h0014, 0);
    chk("tmo_rotate", 1, 4);

    do_reset();
    cyc(1, 16'h0200, 0);
    chk("mid_g9", 1, 9);
    cyc(1, 16'h0200, 1);
    chk("mid_r9", 0, 9);
    cyc(1, 16'h0200, 0);
    chk("mid_g9b", 1, 9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_midgrant", 0, 0);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (10) begin
      cyc(0, 16'hFFFF, 0);
      chk("en0_nogrant", 0, 0);
    end
    cyc(1, 16'h0600, 0);
    chk("ptr_after_rst", 1, 9);

    do_reset();
    r = '0;
    repeat (3000) begin
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0)
          r = 16'(1 << $urandom_range(0, 15));
        else
          r = 16'($urandom) & 16'($urandom);
      end
      cyc(e, r, d);
      chk("rand", m_valid, m_idx);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
